exe_stage_reduced: RTL and testbench

//  Reduced scalar execute stage of the in-order core; sits between register read and write-back.
//  One-cycle ALU (ADD/SUB/AND/OR/XOR) and jump unit (JAL/JALR); multi-cycle MUL and iterative DIV/REM.

---
 rtl/exe_red_pkg.sv | 34 +++
 rtl/exe_red_divider.sv | 110 +++++++++++
 rtl/exe_stage_reduced.sv | 200 ++++++++++++++++++++
 tb/tb_exe_stage_reduced.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_red_pkg.sv
// exe_red_pkg: shared types and constants for the reduced execute stage.
//   XLEN            datapath width
//   unit_t          functional unit selector
//   op_t            opcode
//   JUMP_ALIGN_MASK clears bit 0 of a computed jump target
package exe_red_pkg;

  localparam int XLEN = 64;

  localparam logic [XLEN-1:0] JUMP_ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_MUL    = 2'd1,
    UNIT_DIV    = 2'd2,
    UNIT_BRANCH = 2'd3
  } unit_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_MUL  = 4'd5,
    OP_DIV  = 4'd6,
    OP_DIVU = 4'd7,
    OP_REM  = 4'd8,
    OP_REMU = 4'd9,
    OP_JAL  = 4'd10,
    OP_JALR = 4'd11
  } op_t;

endpackage

// File: rtl/exe_red_divider.sv
// exe_red_divider: iterative restoring radix-2 divider, one quotient bit per cycle.
//   clk_i, rst_i        clock, async active-high reset
//   start_i             load operands (ignored while busy)
//   kill_i              abandon the current division
//   is_signed_i         signed (DIV/REM) vs unsigned (DIVU/REMU)
//   is_rem_i            return remainder instead of quotient
//   dividend_i          rs1
//   divisor_i           rs2
//   busy_o              iterating
//   done_o              final iteration happens at the coming edge
//   result_o            sign-corrected result, valid while done_o=1
// Operands are loaded at the start edge; 64 iterations follow, one per busy
// cycle. The sign/zero fix-up is applied combinationally to the last
// iteration so the caller can register the final value at that same edge.
module exe_red_divider
  import exe_red_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic            is_signed_i,
  input  logic            is_rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  logic            busy_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] dvd_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            is_rem_q;
  logic            dz_q;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  always_comb begin
    a_abs = (is_signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    b_abs = (is_signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
  end

  // Partial remainder is always < divisor, so the shifted value fits XLEN+1
  // bits and a wrapping XLEN-bit subtract gives the exact difference.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvs_q};
    rem_n   = ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], ge};
  end

  always_comb begin
    result_o = '0;
    if (dz_q) begin
      result_o = is_rem_q ? dvd_q : '1;
    end else if (is_rem_q) begin
      result_o = neg_r_q ? -rem_n : rem_n;
    end else begin
      result_o = neg_q_q ? -quo_n : quo_n;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 6'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (busy_q) begin
      if (kill_i || cnt_q == 6'd0) begin
        busy_q <= 1'b0;
      end
      cnt_q <= cnt_q - 6'd1;
      rem_q <= rem_n;
      quo_q <= quo_n;
    end else if (start_i && !kill_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= 6'd63;
      rem_q    <= '0;
      quo_q    <= a_abs;
      dvs_q    <= b_abs;
      dvd_q    <= dividend_i;
      neg_q_q  <= is_signed_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      neg_r_q  <= is_signed_i && dividend_i[XLEN-1];
      is_rem_q <= is_rem_i;
      dz_q     <= (divisor_i == '0);
    end
  end

endmodule

// File: rtl/exe_stage_reduced.sv
// exe_stage_reduced: reduced scalar execute stage.
//   Combinational ALU/jump path: arith_valid_o, arith_result_o,
//   arith_result_pc_o, correct_pred_o.
//   Multi-cycle MUL (MUL_LAT cycles) and iterative DIV/REM (65 cycles):
//   muldiv_valid_o, muldiv_result_o, stall_o, struct_stall_o.
//   Control: clk_i, rst_i (async active-high), kill_i (flush).
// Build option: EXE_DIV_EN includes the iterative divider; without it,
// UNIT_DIV ops finish the next cycle with result 0 and never stall.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | nothing in flight, may accept a mul/div
// ST_MUL_BUS| multiplier latency countdown, stall_o=1
// ST_DIV_BUS| divider iterating, stall_o=1
// ST_DONE   | muldiv_valid_o pulse, may accept a new mul/div
module exe_stage_reduced
  import exe_red_pkg::*;
#(
  parameter int MUL_LAT = 2
)
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            valid_i,
  input  unit_t           unit_i,
  input  op_t             op_i,
  input  logic            use_imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_addr_i,
  output logic            arith_valid_o,
  output logic [XLEN-1:0] arith_result_o,
  output logic [XLEN-1:0] arith_result_pc_o,
  output logic            muldiv_valid_o,
  output logic [XLEN-1:0] muldiv_result_o,
  output logic            stall_o,
  output logic            struct_stall_o,
  output logic            correct_pred_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Busy cycles = MUL_LAT-1; the down-counter terminates at 0.
  localparam logic [7:0] MUL_CNT_INIT = 8'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] mul_a_q, mul_b_q;
  logic [XLEN-1:0] res_q, res_d;
  logic            res_load;
  logic            accept;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  // ALU / jump path
  logic [XLEN-1:0] opb, alu_res, jump_tgt;
  logic            is_jump, arith_en;

  always_comb begin
    opb      = use_imm_i ? imm_i : rs2_i;
    alu_res  = '0;
    jump_tgt = '0;
    is_jump  = 1'b0;
    case (op_i)
      OP_ADD:  alu_res = rs1_i + opb;
      OP_SUB:  alu_res = rs1_i - opb;
      OP_AND:  alu_res = rs1_i & opb;
      OP_OR:   alu_res = rs1_i | opb;
      OP_XOR:  alu_res = rs1_i ^ opb;
      OP_JAL: begin
        alu_res  = pc_i + XLEN'(4);
        jump_tgt = (pc_i + imm_i) & JUMP_ALIGN_MASK;
        is_jump  = 1'b1;
      end
      OP_JALR: begin
        alu_res  = pc_i + XLEN'(4);
        jump_tgt = (rs1_i + imm_i) & JUMP_ALIGN_MASK;
        is_jump  = 1'b1;
      end
      default: ;
    endcase
  end

  assign arith_en          = valid_i && !kill_i && (unit_i == UNIT_ALU || unit_i == UNIT_BRANCH);
  assign arith_valid_o     = arith_en;
  assign arith_result_o    = arith_en ? alu_res : '0;
  assign arith_result_pc_o = arith_en ? jump_tgt : '0;
  assign correct_pred_o    = arith_en && is_jump && pred_taken_i && (pred_addr_i == jump_tgt);

  // Mul/div control
  assign stall_o        = (state_q == ST_MUL_BUSY) || (state_q == ST_DIV_BUSY);
  assign struct_stall_o = valid_i && stall_o;
  assign accept         = valid_i && !kill_i && !stall_o && (unit_i == UNIT_MUL || unit_i == UNIT_DIV);
  assign muldiv_valid_o = (state_q == ST_DONE) && !kill_i;
  assign muldiv_result_o = res_q;

`ifdef EXE_DIV_EN
  logic div_busy;

  exe_red_divider u_divider (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (accept && unit_i == UNIT_DIV),
    .kill_i      (kill_i),
    .is_signed_i (op_i == OP_DIV || op_i == OP_REM),
    .is_rem_i    (op_i == OP_REM || op_i == OP_REMU),
    .dividend_i  (rs1_i),
    .divisor_i   (rs2_i),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .result_o    (div_result)
  );
`else
  assign div_done   = 1'b0;
  assign div_result = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_load = 1'b0;
    res_d    = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (unit_i == UNIT_MUL) begin
            cnt_d = MUL_CNT_INIT;
            if (MUL_LAT == 1) begin
              state_d  = ST_DONE;
              res_load = 1'b1;
              res_d    = rs1_i * rs2_i;
            end else begin
              state_d = ST_MUL_BUSY;
            end
          end else begin
`ifdef EXE_DIV_EN
            state_d = ST_DIV_BUSY;
`else
            state_d  = ST_DONE;
            res_load = 1'b1;
`endif
          end
        end
      end
      ST_MUL_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d  = ST_DONE;
          res_load = 1'b1;
          res_d    = mul_a_q * mul_b_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DIV_BUSY: begin
        if (div_done) begin
          state_d  = ST_DONE;
          res_load = 1'b1;
          res_d    = div_result;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush abandons everything in flight; the held result is untouched.
    if (kill_i) begin
      state_d  = ST_IDLE;
      res_load = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mul_a_q <= rs1_i;
        mul_b_q <= rs2_i;
      end
      if (res_load) begin
        res_q <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_reduced.sv
module tb_exe_stage_reduced;
  import exe_red_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            kill_i;
  logic            valid_i;
  unit_t           unit_i;
  op_t             op_i;
  logic            use_imm_i;
  logic [XLEN-1:0] pc_i, imm_i, rs1_i, rs2_i, pred_addr_i;
  logic            pred_taken_i;
  logic            arith_valid_o;
  logic [XLEN-1:0] arith_result_o, arith_result_pc_o, muldiv_result_o;
  logic            muldiv_valid_o, stall_o, struct_stall_o, correct_pred_o;

  int checks = 0;
  int errors = 0;

  exe_stage_reduced #(.MUL_LAT(2)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .kill_i            (kill_i),
    .valid_i           (valid_i),
    .unit_i            (unit_i),
    .op_i              (op_i),
    .use_imm_i         (use_imm_i),
    .pc_i              (pc_i),
    .imm_i             (imm_i),
    .rs1_i             (rs1_i),
    .rs2_i             (rs2_i),
    .pred_taken_i      (pred_taken_i),
    .pred_addr_i       (pred_addr_i),
    .arith_valid_o     (arith_valid_o),
    .arith_result_o    (arith_result_o),
    .arith_result_pc_o (arith_result_pc_o),
    .muldiv_valid_o    (muldiv_valid_o),
    .muldiv_result_o   (muldiv_result_o),
    .stall_o           (stall_o),
    .struct_stall_o    (struct_stall_o),
    .correct_pred_o    (correct_pred_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    kill_i = 0; valid_i = 0; unit_i = UNIT_ALU; op_i = OP_ADD; use_imm_i = 0;
    pc_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0; pred_taken_i = 0; pred_addr_i = '0;
  endtask

  task automatic issue(input unit_t u, input op_t o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    valid_i = 1; unit_i = u; op_i = o; rs1_i = a; rs2_i = b; use_imm_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    step(); step();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    checks++; if (muldiv_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mdvalid got %b exp 0", muldiv_valid_o); end
    checks++; if (muldiv_result_o !== '0) begin errors++; $display("FAIL reset_mdresult got %h exp 0", muldiv_result_o); end
    rst_i = 0;
    step();
  endtask

  task automatic test_add();
    logic [XLEN-1:0] a, b;
    issue(UNIT_ALU, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    #1;
    checks++; if (arith_valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", arith_valid_o); end
    checks++; if (arith_result_o !== 64'd0) begin errors++; $display("FAIL add_wrap got %h exp 0", arith_result_o); end
    for (int i = 0; i < 100; i++) begin
      a[63:32] = $urandom(); a[31:0] = $urandom();
      b[63:32] = $urandom(); b[31:0] = $urandom();
      rs1_i = a; rs2_i = b;
      #1;
      checks++; if (arith_result_o !== a + b) begin errors++; $display("FAIL add_rand got %h exp %h", arith_result_o, a + b); end
    end
    idle_inputs();
  endtask

  task automatic test_sub();
    logic [XLEN-1:0] a, b;
    issue(UNIT_ALU, OP_SUB, 64'd5, 64'd7);
    #1;
    checks++; if (arith_result_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg got %h exp fffffffffffffffe", arith_result_o); end
    for (int i = 0; i < 100; i++) begin
      a[63:32] = $urandom(); a[31:0] = $urandom();
      b[63:32] = $urandom(); b[31:0] = $urandom();
      rs1_i = a; rs2_i = b;
      #1;
      checks++; if (arith_result_o !== a - b) begin errors++; $display("FAIL sub_rand got %h exp %h", arith_result_o, a - b); end
    end
    idle_inputs();
  endtask

  task automatic test_logic();
    issue(UNIT_ALU, OP_AND, 64'hF0F0_1234_5678_00FF, 64'h1111_1111_1111_1111);
    use_imm_i = 1; imm_i = 64'h0FF0_FFFF_0000_0F0F;
    #1;
    checks++; if (arith_result_o !== 64'h00F0_1234_0000_000F) begin errors++; $display("FAIL and_imm got %h exp 00f012340000000f", arith_result_o); end
    op_i = OP_OR; #1;
    checks++; if (arith_result_o !== 64'hFFF0_FFFF_5678_0FFF) begin errors++; $display("FAIL or_imm got %h exp fff0ffff56780fff", arith_result_o); end
    op_i = OP_XOR; use_imm_i = 0; #1;
    checks++; if (arith_result_o !== 64'hE1E1_0325_4769_11EE) begin errors++; $display("FAIL xor_rs2 got %h exp e1e10325476911ee", arith_result_o); end
    op_i = OP_ADD; use_imm_i = 1; rs1_i = 64'd10; imm_i = 64'hFFFF_FFFF_FFFF_FFFD; #1;
    checks++; if (arith_result_o !== 64'd7) begin errors++; $display("FAIL add_imm got %h exp 7", arith_result_o); end
    kill_i = 1; #1;
    checks++; if (arith_valid_o !== 1'b0) begin errors++; $display("FAIL kill_gates_valid got %b exp 0", arith_valid_o); end
    kill_i = 0; valid_i = 0; #1;
    checks++; if (arith_valid_o !== 1'b0 || arith_result_o !== '0) begin errors++; $display("FAIL invalid_zero got v=%b r=%h exp 0/0", arith_valid_o, arith_result_o); end
    valid_i = 1; unit_i = UNIT_MUL; #1;
    checks++; if (arith_valid_o !== 1'b0) begin errors++; $display("FAIL mul_unit_no_arith got %b exp 0", arith_valid_o); end
    idle_inputs();
    #1;
  endtask

  task automatic test_jal();
    idle_inputs();
    valid_i = 1; unit_i = UNIT_BRANCH; op_i = OP_JAL; pc_i = 64'h1000; imm_i = 64'h23;
    pred_taken_i = 1; pred_addr_i = 64'h1022;
    #1;
    checks++; if (arith_result_o !== 64'h1004) begin errors++; $display("FAIL jal_link got %h exp 1004", arith_result_o); end
    checks++; if (arith_result_pc_o !== 64'h1022) begin errors++; $display("FAIL jal_target got %h exp 1022", arith_result_pc_o); end
    checks++; if (correct_pred_o !== 1'b1) begin errors++; $display("FAIL jal_pred_ok got %b exp 1", correct_pred_o); end
    pred_addr_i = 64'h1023; #1;
    checks++; if (correct_pred_o !== 1'b0) begin errors++; $display("FAIL jal_pred_addr got %b exp 0", correct_pred_o); end
    pred_addr_i = 64'h1022; pred_taken_i = 0; #1;
    checks++; if (correct_pred_o !== 1'b0) begin errors++; $display("FAIL jal_pred_nottaken got %b exp 0", correct_pred_o); end
    pred_taken_i = 1; unit_i = UNIT_ALU; op_i = OP_ADD; rs1_i = 64'h1022; #1;
    checks++; if (correct_pred_o !== 1'b0) begin errors++; $display("FAIL nonjump_pred got %b exp 0", correct_pred_o); end
    idle_inputs();
  endtask

  task automatic test_jalr();
    idle_inputs();
    valid_i = 1; unit_i = UNIT_BRANCH; op_i = OP_JALR; pc_i = 64'h3000; rs1_i = 64'h2001; imm_i = 64'd4;
    pred_taken_i = 1; pred_addr_i = 64'h2004;
    #1;
    checks++; if (arith_result_pc_o !== 64'h2004) begin errors++; $display("FAIL jalr_target got %h exp 2004", arith_result_pc_o); end
    checks++; if (arith_result_o !== 64'h3004) begin errors++; $display("FAIL jalr_link got %h exp 3004", arith_result_o); end
    checks++; if (correct_pred_o !== 1'b1) begin errors++; $display("FAIL jalr_pred got %b exp 1", correct_pred_o); end
    idle_inputs();
  endtask

  task automatic test_mul();
    issue(UNIT_MUL, OP_MUL, 64'h1_0000_0003, 64'h10);
    step();
    idle_inputs();
    valid_i = 1; unit_i = UNIT_ALU; #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL mul_stall got %b exp 1", stall_o); end
    checks++; if (muldiv_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early_valid got %b exp 0", muldiv_valid_o); end
    checks++; if (struct_stall_o !== 1'b1) begin errors++; $display("FAIL struct_stall got %b exp 1", struct_stall_o); end
    step();
    valid_i = 0; #1;
    checks++; if (muldiv_valid_o !== 1'b1) begin errors++; $display("FAIL mul_valid got %b exp 1", muldiv_valid_o); end
    checks++; if (muldiv_result_o !== 64'h10_0000_0030) begin errors++; $display("FAIL mul_result got %h exp 1000000030", muldiv_result_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mul_done_stall got %b exp 0", stall_o); end
    step();
    checks++; if (muldiv_valid_o !== 1'b0 || muldiv_result_o !== 64'h10_0000_0030) begin errors++; $display("FAIL mul_hold got v=%b r=%h exp 0/1000000030", muldiv_valid_o, muldiv_result_o); end
  endtask

  task automatic test_back_to_back();
    issue(UNIT_MUL, OP_MUL, 64'd3, 64'd5);
    step();
    valid_i = 0;
    step();
    checks++; if (muldiv_valid_o !== 1'b1 || muldiv_result_o !== 64'd15) begin errors++; $display("FAIL b2b_first got v=%b r=%h exp 1/f", muldiv_valid_o, muldiv_result_o); end
    issue(UNIT_MUL, OP_MUL, 64'd7, 64'd9);
    step();
    valid_i = 0; #1;
    checks++; if (stall_o !== 1'b1 || muldiv_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_accept got s=%b v=%b exp 1/0", stall_o, muldiv_valid_o); end
    step();
    checks++; if (muldiv_valid_o !== 1'b1 || muldiv_result_o !== 64'd63) begin errors++; $display("FAIL b2b_second got v=%b r=%h exp 1/3f", muldiv_valid_o, muldiv_result_o); end
    idle_inputs();
    step();
  endtask

  task automatic test_kill();
    issue(UNIT_MUL, OP_MUL, 64'd2, 64'd2);
    step();
    unit_i = UNIT_ALU; kill_i = 1; #1;
    checks++; if (arith_valid_o !== 1'b0) begin errors++; $display("FAIL kill_arith got %b exp 0", arith_valid_o); end
    step();
    idle_inputs(); #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL kill_stall got %b exp 0", stall_o); end
    checks++; if (muldiv_result_o !== 64'd63) begin errors++; $display("FAIL kill_result_held got %h exp 3f", muldiv_result_o); end
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        if (muldiv_valid_o) seen++;
        step();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_pulse got %0d pulses exp 0", seen); end
    end
  endtask

`ifdef EXE_DIV_EN
  task automatic test_div();
    op_t             d_op [9] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU};
    logic [XLEN-1:0] d_a  [9] = '{-64'sd100, -64'sd100, 64'd100, 64'd100, -64'sd100, -64'sd100,
                                  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [XLEN-1:0] d_b  [9] = '{64'd7, 64'd7, 64'd7, 64'd7, 64'd0, 64'd0, '1, '1, 64'd3};
    logic [XLEN-1:0] d_e  [9] = '{-64'sd14, -64'sd2, 64'd14, 64'd2, '1, -64'sd100,
                                  64'h8000_0000_0000_0000, 64'd0, 64'h5555_5555_5555_5555};
    for (int v = 0; v < 9; v++) begin
      int n = 0;
      int stall_bad = 0;
      issue(UNIT_DIV, d_op[v], d_a[v], d_b[v]);
      step();
      valid_i = 0; n = 1;
      while (!muldiv_valid_o && n < 100) begin
        if (stall_o !== 1'b1) stall_bad++;
        step();
        n++;
      end
      checks++; if (n !== 65) begin errors++; $display("FAIL div_latency[%0d] got %0d exp 65", v, n); end
      checks++; if (stall_bad !== 0) begin errors++; $display("FAIL div_busy_stall[%0d] got %0d low cycles exp 0", v, stall_bad); end
      checks++; if (muldiv_result_o !== d_e[v]) begin errors++; $display("FAIL div_result[%0d] got %h exp %h", v, muldiv_result_o, d_e[v]); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL div_done_stall[%0d] got %b exp 0", v, stall_o); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_kill_div();
    int seen = 0;
    issue(UNIT_DIV, OP_DIV, 64'd1000, 64'd3);
    step();
    valid_i = 0;
    for (int i = 0; i < 10; i++) step();
    kill_i = 1;
    step();
    kill_i = 0;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL kill_div_stall got %b exp 0", stall_o); end
    for (int i = 0; i < 70; i++) begin
      if (muldiv_valid_o) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL kill_div_pulse got %0d exp 0", seen); end
  endtask
`else
  task automatic test_div();
    issue(UNIT_DIV, OP_DIV, -64'sd100, 64'd7);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL nodiv_stall_issue got %b exp 0", stall_o); end
    step();
    valid_i = 0; #1;
    checks++; if (muldiv_valid_o !== 1'b1) begin errors++; $display("FAIL nodiv_valid got %b exp 1", muldiv_valid_o); end
    checks++; if (muldiv_result_o !== '0) begin errors++; $display("FAIL nodiv_result got %h exp 0", muldiv_result_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL nodiv_stall got %b exp 0", stall_o); end
    step();
    checks++; if (muldiv_valid_o !== 1'b0) begin errors++; $display("FAIL nodiv_single_pulse got %b exp 0", muldiv_valid_o); end
    idle_inputs();
  endtask

  task automatic test_kill_div();
  endtask
`endif

  task automatic test_reset_mid_op();
    issue(UNIT_MUL, OP_MUL, 64'd11, 64'd11);
    step();
    idle_inputs();
    rst_i = 1; #1;
    checks++; if (stall_o !== 1'b0 || muldiv_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got s=%b v=%b exp 0/0", stall_o, muldiv_valid_o); end
    step();
    rst_i = 0;
    step();
    checks++; if (muldiv_valid_o !== 1'b0 || muldiv_result_o !== '0) begin errors++; $display("FAIL rst_mid_result got v=%b r=%h exp 0/0", muldiv_valid_o, muldiv_result_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_jal();
    test_jalr();
    test_mul();
    test_back_to_back();
    test_kill();
    test_div();
    test_kill_div();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
